// File: rtl/cs_word_pipe_if.sv
// Sequencer-side and mapper-side signals of the control-word pipeline.
// The slave modport is the pipeline's view; the master modport is its environment's.
interface cs_word_pipe_if #(
  parameter int unsigned CS_WIDTH  = 62,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CS_WIDTH-1:0]  in_word;
  logic                 in_parity;
  logic                 stall;
  logic                 flush;
  logic                 out_valid;
  logic [CS_WIDTH-1:0]  out_word;
  logic [CNT_WIDTH-1:0] retire_count;
  logic                 parity_err;

  modport master (
    output in_valid, in_word, in_parity, stall, flush,
    input  in_ready, out_valid, out_word, retire_count, parity_err
  );

  modport slave (
    input  in_valid, in_word, in_parity, stall, flush,
    output in_ready, out_valid, out_word, retire_count, parity_err
  );
endinterface

// File: rtl/cs_word_pipe.sv
// Control-word pipeline with stall/flush/bubble, NOP masking of empty slots and a retire counter.
// Define CS_PARITY_EN to enable the sticky even-parity check on accepted words.
module cs_word_pipe #(
  parameter int unsigned         CS_WIDTH  = 62,
  parameter int unsigned         DEPTH     = 2,
  parameter logic [CS_WIDTH-1:0] NOP_WORD  = '0,
  parameter int unsigned         CNT_WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  cs_word_pipe_if.slave bus
);
  logic                 advance;
  logic                 accept;
  logic                 retire;
  logic [CS_WIDTH-1:0]  load_word;
  logic [DEPTH-1:0]     v_q, v_d;
  logic [CS_WIDTH-1:0]  d_q [DEPTH];
  logic [CS_WIDTH-1:0]  d_d [DEPTH];
  logic [CNT_WIDTH-1:0] retire_q, retire_d;

  assign advance = !bus.stall && !bus.flush;
  assign accept  = bus.in_valid && advance;
  assign retire  = v_q[DEPTH-1] && advance;

`ifdef CS_PARITY_EN
  logic par_bad;
  logic parity_q, parity_d;

  assign par_bad = ^{bus.in_word, bus.in_parity};
  // A faulting word still takes its slot, but travels as a harmless NOP
  assign load_word = par_bad ? NOP_WORD : bus.in_word;
  assign parity_d  = parity_q | (accept & par_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end

  assign bus.parity_err = parity_q;
`else
  logic unused_parity;

  assign unused_parity  = bus.in_parity;
  assign load_word      = bus.in_word;
  assign bus.parity_err = 1'b0;
`endif

  always_comb begin
    v_d      = v_q;
    d_d      = d_q;
    retire_d = retire_q;
    if (bus.flush) begin
      v_d = '0;
    end else if (!bus.stall) begin
      v_d[0] = accept;
      d_d[0] = load_word;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
    if (retire) retire_d = retire_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q      <= '0;
      retire_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) d_q[k] <= NOP_WORD;
    end else begin
      v_q      <= v_d;
      d_q      <= d_d;
      retire_q <= retire_d;
    end
  end

  assign bus.in_ready     = advance;
  assign bus.out_valid    = v_q[DEPTH-1];
  assign bus.out_word     = v_q[DEPTH-1] ? d_q[DEPTH-1] : NOP_WORD;
  assign bus.retire_count = retire_q;
endmodule

// File: tb/tb_cs_word_pipe.sv
// Directed, table-driven bench for cs_word_pipe (DEPTH=2, CNT_WIDTH=4, non-zero NOP word).
module tb_cs_word_pipe;
  localparam int unsigned         CSW = 12;
  localparam int unsigned         DEP = 2;
  localparam int unsigned         CW  = 4;
  localparam logic [CSW-1:0]      NOP = 12'hA5A;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cs_word_pipe_if #(.CS_WIDTH(CSW), .CNT_WIDTH(CW)) bus ();

  cs_word_pipe #(
    .CS_WIDTH (CSW),
    .DEPTH    (DEP),
    .NOP_WORD (NOP),
    .CNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           iv;
    logic [CSW-1:0] w;
    logic           st;
    logic           fl;
    logic           ev;
    logic [CSW-1:0] ew;
    logic           er;
    logic [CW-1:0]  ec;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic iv, input logic [CSW-1:0] w, input logic st,
                              input logic fl, input logic ev, input logic [CSW-1:0] ew,
                              input logic er, input logic [CW-1:0] ec);
    vec_t v;
    v.iv = iv; v.w = w; v.st = st; v.fl = fl;
    v.ev = ev; v.ew = ew; v.er = er; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [CSW-1:0] w, input logic st, input logic fl);
    bus.in_valid  = iv;
    bus.in_word   = w;
    bus.in_parity = ^w;
    bus.stall     = st;
    bus.flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);

    // Each entry: inputs for this cycle, outputs expected before the next edge
    tbl.push_back(mk(1, 12'h3A5, 0, 0, 0, NOP,     1, 4'd0));
    tbl.push_back(mk(1, 12'h001, 0, 0, 0, NOP,     1, 4'd0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 12'h3A5, 1, 4'd0));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 12'h001, 1, 4'd1));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd2));
    tbl.push_back(mk(1, 12'h155, 0, 0, 0, NOP,     1, 4'd2));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd2));
    tbl.push_back(mk(1, 12'h777, 1, 0, 1, 12'h155, 0, 4'd2));
    tbl.push_back(mk(1, 12'h777, 1, 0, 1, 12'h155, 0, 4'd2));
    tbl.push_back(mk(1, 12'h777, 1, 0, 1, 12'h155, 0, 4'd2));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 12'h155, 1, 4'd2));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h0AA, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h0BB, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h0CC, 0, 1, 1, 12'h0AA, 0, 4'd3));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h111, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h222, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h333, 1, 1, 1, 12'h111, 0, 4'd3));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h01F, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd3));
    tbl.push_back(mk(1, 12'h0E0, 0, 0, 1, 12'h01F, 1, 4'd3));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd4));
    tbl.push_back(mk(0, 12'h000, 0, 0, 1, 12'h0E0, 1, 4'd4));
    tbl.push_back(mk(0, 12'h000, 0, 0, 0, NOP,     1, 4'd5));

    // Reset state
    repeat (2) tick();
    chk("rst.valid",  32'(bus.out_valid),    32'd0);
    chk("rst.word",   32'(bus.out_word),     32'(NOP));
    chk("rst.count",  32'(bus.retire_count), 32'd0);
    chk("rst.ready",  32'(bus.in_ready),     32'd1);
    chk("rst.parity", 32'(bus.parity_err),   32'd0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].w, tbl[i].st, tbl[i].fl);
      #1;
      chk($sformatf("v%0d.valid", i), 32'(bus.out_valid),    32'(tbl[i].ev));
      chk($sformatf("v%0d.word",  i), 32'(bus.out_word),     32'(tbl[i].ew));
      chk($sformatf("v%0d.ready", i), 32'(bus.in_ready),     32'(tbl[i].er));
      chk($sformatf("v%0d.count", i), 32'(bus.retire_count), 32'(tbl[i].ec));
      tick();
    end

    // Asynchronous reset with words in flight
    drive(1'b1, 12'h0F0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 12'h0F1, 1'b0, 1'b0);
    tick();
    chk("midrst.pre_word", 32'(bus.out_word), 32'h0F0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(bus.out_valid),    32'd0);
    chk("midrst.word",  32'(bus.out_word),     32'(NOP));
    chk("midrst.count", 32'(bus.retire_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 17 back-to-back retirements wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, CSW'(i + 1), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("wrap.count", 32'(bus.retire_count), 32'd1);
    chk("wrap.valid", 32'(bus.out_valid),    32'd0);

    // Parity: 0x001 with parity 0 is odd overall
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 12'h001, 1'b0, 1'b0);
    bus.in_parity = 1'b0;
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("par.valid", 32'(bus.out_valid), 32'd1);
`ifdef CS_PARITY_EN
    chk("par.err",  32'(bus.parity_err), 32'd1);
    chk("par.word", 32'(bus.out_word),   32'(NOP));
`else
    chk("par.err",  32'(bus.parity_err), 32'd0);
    chk("par.word", 32'(bus.out_word),   32'h001);
`endif
    drive(1'b1, 12'h003, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    chk("par.good_word", 32'(bus.out_word), 32'h003);
`ifdef CS_PARITY_EN
    chk("par.sticky", 32'(bus.parity_err), 32'd1);
`else
    chk("par.sticky", 32'(bus.parity_err), 32'd0);
`endif
    chk("par.count", 32'(bus.retire_count), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("par.cleared", 32'(bus.parity_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cs_word_pipe.md
# cs_word_pipe

Parametrised control-word pipeline between the microcode sequencer and the control-signal field mapper in the CPU core. Registers a CS_WIDTH-bit control word through DEPTH stages with stall, flush and bubble insertion. Any non-valid output slot presents a programmable NOP word, so downstream write and bus strobes can never fire from a stale word. Also counts retired words and, optionally, checks word parity.

## Interface
Parameters:
- CS_WIDTH, 62, control word width in bits (≥1)
- DEPTH, 2, pipeline stages (≥1)
- NOP_WORD, {CS_WIDTH{1'b0}}, word driven whenever the output is not valid
- CNT_WIDTH, 16, retired-word counter width

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_word is presented
- in_ready  output  1  stage 0 can accept this cycle
- in_word  input  CS_WIDTH  control word from sequencer
- in_parity  input  1  even-parity bit for in_word (used only with CS_PARITY_EN)
- stall  input  1  freeze all stages
- flush  input  1  invalidate all stages
- out_valid  output  1  last stage holds a valid word
- out_word  output  CS_WIDTH  last-stage word, or NOP_WORD when not valid
- retire_count  output  CNT_WIDTH  number of words retired
- parity_err  output  1  sticky parity error (tied 0 without CS_PARITY_EN)

## Operation
- Each stage k holds a valid bit v[k] and a data register d[k]. Stage DEPTH-1 drives the outputs.
- in_ready = !stall && !flush, combinational.
- Accept: in_valid && in_ready. On accept, d[0] <= in_word and v[0] <= 1.
- Bubble: when not stalled, not flushed and not accepting, v[0] <= 0. d[0] is don't-care.
- Advance: when !stall && !flush, v[k] <= v[k-1] and d[k] <= d[k-1] for k ≥ 1, every cycle, regardless of downstream state. There is no backpressure apart from stall.
- Stall (flush=0): every v and d holds. The output word is re-presented unchanged.
- Flush: every v[k] <= 0 next cycle. Flush overrides stall. The input word in the flush cycle is discarded.
- out_valid = v[DEPTH-1]. out_word = v[DEPTH-1] ? d[DEPTH-1] : NOP_WORD, muxed combinationally from registered state.
- Retire: out_valid && !stall && !flush. On retire, retire_count increments by 1, wrapping modulo 2^CNT_WIDTH. A flushed word is not retired.
- Reset: all v = 0, all d = NOP_WORD, retire_count = 0, parity_err = 0. Therefore out_valid = 0, out_word = NOP_WORD, in_ready = !stall && !flush.
- Reset asserted mid-stream discards all in-flight words immediately (asynchronous). The outputs show NOP_WORD during reset.

## Timing
- Latency: a word accepted at edge N appears on out_word after edge N+DEPTH-1 (available to be retired in the cycle following that edge), provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: one word per cycle.
- DEPTH=1: the word is visible in the cycle after acceptance.
- With flush and stall asserted together, the pipeline is empty one cycle later.
- No combinational path from in_word to out_word.

## Configuration
- CS_PARITY_EN defined: on each accept, if ^{in_word, in_parity} != 0, parity_err <= 1 (sticky, cleared only by reset). The faulting word is still accepted and loaded as NOP_WORD, never as the erroneous word.
- CS_PARITY_EN undefined: in_parity is ignored, parity_err is constant 0, and no parity logic is instantiated.

## Test plan
- Reset → out_valid=0, out_word=NOP_WORD, retire_count=0. With DEPTH=2, feed 0x3A5 then 0x001 on consecutive cycles → the words appear after edges N+1 and N+2, and retire_count=2.
- Stall for 3 cycles with word 0x155 in the last stage → out_word stays 0x155, in_ready=0, retire_count does not change. After release → 0x155 retires once.
- Flush with two valid words in flight while in_valid=1 → out_valid=0 next cycle and both words plus the input word are lost. Assert flush together with stall → same result.
- in_valid low for one cycle between words → a single NOP_WORD bubble with out_valid=0. retire_count counts only the valid words.
- CNT_WIDTH=4, retire 17 words → retire_count=1.
- CS_PARITY_EN: send in_word=0x1 with in_parity=0 → parity_err=1, the stage outputs NOP_WORD, and parity_err remains 1 after later good words until rst_n is asserted.
